borrow_lookahead_sub_serial: RTL and testbench

Multi-cycle subtractor computing A − B − Bin on WIDTH-bit operands, one 4-bit digit per clock. Each digit uses a 4-bit borrow-lookahead slice, the subtract-direction counterpart of the team's 4-bit carry-lookahead adder. Operands enter and results leave over valid/ready handshakes. Intended for wide datapaths where a full-width combinational subtractor is not worth the area.

---
 rtl/borrow_lookahead_sub_serial_pkg.sv | 32 +++
 rtl/borrow_lookahead_sub_serial_sub4.sv | 45 ++++
 rtl/borrow_lookahead_sub_serial.sv | 134 +++++++++++++
 tb/tb_borrow_lookahead_sub_serial.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/borrow_lookahead_sub_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : borrow_lookahead_sub_serial_pkg
//  Purpose  : Shared types and sizing helpers for the digit-serial
//             borrow-lookahead subtractor.
//  Revision : 1.0  initial release
// ============================================================================
package borrow_lookahead_sub_serial_pkg;

    // One borrow-lookahead slice handles this many bits per clock
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digits needed to cover an operand of the given width
    function automatic int calc_digits(input int width);
        return width / DIGIT_W;
    endfunction

    // Width of the digit counter; never narrower than one bit
    function automatic int calc_cnt_w(input int width);
        int n;
        n = width / DIGIT_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/borrow_lookahead_sub_serial_sub4.sv
`default_nettype none
// ============================================================================
//  Module   : borrow_lookahead_sub4
//  Purpose  : Purely combinational 4-bit borrow-lookahead subtract slice,
//             d = a - b - bin, with all internal borrows derived directly
//             from bin (no ripple chain).
//  Revision : 1.0  initial release
// ============================================================================
module borrow_lookahead_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] w_g;    // bit generates a borrow (a=0, b=1)
    logic [3:0] w_p;    // bit propagates an incoming borrow (a==b)
    logic [4:0] w_br;   // borrow into each bit, plus borrow out

    assign w_g = ~a & b;
    assign w_p = ~(a ^ b);

    // Each borrow expanded as a flat sum of products from bin
    assign w_br[0] = bin;
    assign w_br[1] = w_g[0]
                   | (w_p[0] & bin);
    assign w_br[2] = w_g[1]
                   | (w_p[1] & w_g[0])
                   | (w_p[1] & w_p[0] & bin);
    assign w_br[3] = w_g[2]
                   | (w_p[2] & w_g[1])
                   | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & bin);
    assign w_br[4] = w_g[3]
                   | (w_p[3] & w_g[2])
                   | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bin);

    assign d    = a ^ b ^ w_br[3:0];
    assign bout = w_br[4];

endmodule
`default_nettype wire

// File: rtl/borrow_lookahead_sub_serial.sv
`default_nettype none
// ============================================================================
//  Module   : borrow_lookahead_sub_serial
//  Purpose  : Digit-serial subtractor, Diff = A - B - Bin mod 2^WIDTH,
//             one 4-bit borrow-lookahead digit per clock, valid/ready on
//             both operand and result sides.
//  Options  : SUB_OVERFLOW_EN - adds the signed overflow output.
//  Note     : WIDTH must be a multiple of 4 and at least 8.
//  Revision : 1.0  initial release
// ============================================================================
module borrow_lookahead_sub_serial
    import borrow_lookahead_sub_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int               N     = calc_digits(WIDTH);
    localparam int               CNT_W = calc_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_diff;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIGIT_W-1:0] w_d4;
    logic               w_bout4;

    // Single slice, fed by the low digit of the shifting operands
    borrow_lookahead_sub4 u_slice (
        .a    (r_a_sh[DIGIT_W-1:0]),
        .b    (r_b_sh[DIGIT_W-1:0]),
        .bin  (r_br),
        .d    (w_d4),
        .bout (w_bout4)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept in IDLE, run N digits, hold result until taken
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)       w_state_nxt = RUN;
            RUN:     if (r_cnt == LAST)  w_state_nxt = DONE;
            DONE:    if (out_ready)      w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands on accept, then shift one digit per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_diff <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh <= A;
                        r_b_sh <= B;
                        r_br   <= Bin;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_a_sh <= r_a_sh >> DIGIT_W;
                    r_b_sh <= r_b_sh >> DIGIT_W;
                    r_diff <= {w_d4, r_diff[WIDTH-1:DIGIT_W]};
                    r_br   <= w_bout4;
                    r_cnt  <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only, so no input-to-output path
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign Diff      = r_diff;
    assign Bout      = (r_state == DONE) & r_br;

`ifdef SUB_OVERFLOW_EN
    logic r_a_msb;
    logic r_b_msb;

    // Operand sign bits captured on accept for the overflow decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if ((r_state == IDLE) && in_valid) begin
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
        end
    end

    // Signed overflow: operand signs differ and result sign left A's sign
    assign overflow = (r_state == DONE)
                    && (r_a_msb != r_b_msb)
                    && (r_diff[WIDTH-1] != r_a_msb);
`endif

endmodule
`default_nettype wire

// File: tb/tb_borrow_lookahead_sub_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_borrow_lookahead_sub_serial
//  Purpose  : Self-checking bench for borrow_lookahead_sub_serial (WIDTH=16).
//             Directed vectors with literal expectations plus an arithmetic
//             reference model compared every cycle.
//  Options  : SUB_OVERFLOW_EN - also exercises the overflow output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_borrow_lookahead_sub_serial;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A         = '0;
    logic [WIDTH-1:0] B         = '0;
    logic             Bin       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
`ifdef SUB_OVERFLOW_EN
    logic             overflow;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    borrow_lookahead_sub_serial #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: whole-word arithmetic, transaction-level timing
    // (0 = waiting for operands, 1 = computing, 2 = result offered)
    // ------------------------------------------------------------------
    int               m_phase = 0;
    int               m_steps = 0;
    logic [WIDTH-1:0] m_diff  = '0;
    logic             m_bout  = 1'b0;
    logic             m_ovf   = 1'b0;
    logic [WIDTH:0]   m_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_steps <= 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_full  = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Bin};
                    m_diff  <= m_full[WIDTH-1:0];
                    m_bout  <= m_full[WIDTH];
                    m_ovf   <= (A[WIDTH-1] != B[WIDTH-1]) && (m_full[WIDTH-1] != A[WIDTH-1]);
                    m_steps <= 0;
                    m_phase <= 1;
                end
                1: begin
                    m_steps <= m_steps + 1;
                    if (m_steps == N - 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            check_bit("in_ready", in_ready, m_phase == 0);
            check_bit("out_valid", out_valid, m_phase == 2);
            if (m_phase == 2) begin
                check_word("model_diff", Diff, m_diff);
                check_bit("model_bout", Bout, m_bout);
`ifdef SUB_OVERFLOW_EN
                check_bit("model_ovf", overflow, m_ovf);
`endif
            end else begin
`ifdef SUB_OVERFLOW_EN
                check_bit("ovf_outside_done", overflow, 1'b0);
`endif
            end
        end
    end

    // One full transaction with literal expectations and optional backpressure
    task automatic txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bin, input logic [WIDTH-1:0] ed,
                       input logic eb, input logic eo, input int hold);
        int lat;
        @(negedge clk);
        check_bit("idle_before_txn", in_ready, 1'b1);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        A = ~a; B = a ^ 16'h5A5A; Bin = ~bin;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_int("latency", lat, N);
        check_word("lit_diff", Diff, ed);
        check_bit("lit_bout", Bout, eb);
`ifdef SUB_OVERFLOW_EN
        check_bit("lit_ovf", overflow, eo);
`else
        if (eo) begin end
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            A = a + 16'h0101; B = b ^ 16'hFFFF;
            @(negedge clk);
            check_word("hold_diff", Diff, ed);
            check_bit("hold_bout", Bout, eb);
            check_bit("hold_in_ready", in_ready, 1'b0);
            check_bit("hold_out_valid", out_valid, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_bit("in_ready_after_release", in_ready, 1'b1);
        check_bit("out_valid_after_release", out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #12;
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_word("reset_diff", Diff, 16'h0000);
        check_bit("reset_bout", Bout, 1'b0);
`ifdef SUB_OVERFLOW_EN
        check_bit("reset_ovf", overflow, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        txn(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 0);
        txn(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0);
        txn(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
        txn(16'h0006, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b0, 0);
        txn(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0);
        txn(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 3);
        txn(16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 0);

        // Reset during the second RUN cycle discards the transaction
        @(negedge clk);
        A = 16'h4321; B = 16'h1111; Bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_bit("midrun_rst_out_valid", out_valid, 1'b0);
        check_bit("midrun_rst_in_ready", in_ready, 1'b1);
        check_word("midrun_rst_diff", Diff, 16'h0000);
        check_bit("midrun_rst_bout", Bout, 1'b0);
`ifdef SUB_OVERFLOW_EN
        check_bit("midrun_rst_ovf", overflow, 1'b0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        txn(16'h1000, 16'h2000, 1'b0, 16'hF000, 1'b1, 1'b0, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
